// File: rtl/sqrt_rom_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_rom_pkg
// Shared constants for the square-root ROM arbiter slice.
//
// Configuration macro: SQRT_ROM_ARB_OUT_REG_EN
//   defined     -> ROM built with its output register, lookup latency LAT = 2
//   not defined -> ROM unregistered (synchronous read only), LAT = 1
//
// Contents:
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default ROM port widths
//   NUM_REQ_MIN / NUM_REQ_MAX       : legal range of requester count
//   LAT                             : clocks from grant to ROM data valid
//   rr_next_idx()                   : round-robin successor of an index
// -----------------------------------------------------------------------------
package sqrt_rom_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 8;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

`ifdef SQRT_ROM_ARB_OUT_REG_EN
    // Address register plus output register inside the ROM.
    localparam int LAT = 2;
`else
    // Address register only inside the ROM.
    localparam int LAT = 1;
`endif

    // Successor of idx in a ring of n entries (wraps n-1 -> 0).
    function automatic int unsigned rr_next_idx(input int unsigned idx,
                                                input int unsigned n);
        int unsigned nxt;
        if ((idx + 32'd1) >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage : sqrt_rom_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. The search begins at the
// requester indexed by i_ptr and walks upward with wrap-around; the first
// active request found is granted. At most one grant bit is ever set.
//
// Ports:
//   i_req [NUM_REQ-1:0] : request vector
//   i_ptr [PTR_W-1:0]   : index where the search starts (must be < NUM_REQ)
//   o_gnt [NUM_REQ-1:0] : one-hot grant, all zero when i_req is all zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Rotating priority search starting at i_ptr.
    always_comb begin
        o_gnt   = {NUM_REQ{1'b0}};
        w_found = 1'b0;
        w_sum   = {(PTR_W + 1){1'b0}};
        w_idx   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/sqrt_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_rom_arbiter
// Shares one square-root lookup ROM between NUM_REQ requesters. One request
// is granted per cycle in round-robin order; the grant is tracked through an
// in-flight shift register of depth LAT so resp_valid marks the owner of
// resp_data when the ROM returns it. Responses have no backpressure.
//
// Configuration macro: SQRT_ROM_ARB_OUT_REG_EN (selects LAT via sqrt_rom_pkg;
// defined -> LAT = 2 for a ROM with output register, else LAT = 1).
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_valid    : per-requester lookup request            [NUM_REQ]
//   req_addr     : per-requester address, slice i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    : one-hot grant (combinational)            [NUM_REQ]
//   resp_valid   : one-hot owner of resp_data this cycle    [NUM_REQ]
//   resp_data    : ROM read data shared by all requesters   [DATA_WIDTH]
//   rom_addr     : address driven to the ROM                [ADDR_WIDTH]
//   rom_rd_data  : data returned by the ROM                 [DATA_WIDTH]
//   rom_rst      : active-high ROM reset, ~rst_n
// -----------------------------------------------------------------------------
module sqrt_rom_arbiter
    import sqrt_rom_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_rd_data,
    output logic                          rom_rst
);

    localparam int PTR_W = $clog2(NUM_REQ);

    generate
        if ((NUM_REQ < NUM_REQ_MIN) || (NUM_REQ > NUM_REQ_MAX)) begin : g_bad_num_req
            $error("sqrt_rom_arbiter: NUM_REQ out of range");
        end
    endgenerate

    logic [PTR_W-1:0]      r_ptr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [NUM_REQ-1:0]    r_inflight [LAT];

    logic [NUM_REQ-1:0]    w_req_gated;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_any_gnt;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;

    // Requests are masked while reset is held so no grant is visible then;
    // this keeps req_ready at zero during reset without a registered stage.
    assign w_req_gated = req_valid & {NUM_REQ{rst_n}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req (w_req_gated),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_any_gnt = |w_gnt;

    // Decode the one-hot grant into an index and select that address.
    always_comb begin
        w_gnt_idx  = {PTR_W{1'b0}};
        w_gnt_addr = {ADDR_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = PTR_W'(i);
                w_gnt_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                w_gnt_idx  = w_gnt_idx;
                w_gnt_addr = w_gnt_addr;
            end
        end
    end

    // Round-robin pointer: next search starts after the requester just served.
    // Only an actual grant moves it, so a withdrawn request costs no turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= {PTR_W{1'b0}};
        end else if (w_any_gnt) begin
            r_ptr <= PTR_W'(rr_next_idx(int'(w_gnt_idx), NUM_REQ));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Last granted address, replayed onto rom_addr on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= {ADDR_WIDTH{1'b0}};
        end else if (w_any_gnt) begin
            r_rom_addr <= w_gnt_addr;
        end else begin
            r_rom_addr <= r_rom_addr;
        end
    end

    // In-flight tracker: grant vector delayed by the ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_inflight[s] <= {NUM_REQ{1'b0}};
            end
        end else begin
            r_inflight[0] <= w_gnt;
            for (int s = 1; s < LAT; s++) begin
                r_inflight[s] <= r_inflight[s-1];
            end
        end
    end

    assign req_ready  = w_gnt;
    // Same-cycle address lets the ROM capture it on the grant edge.
    assign rom_addr   = w_any_gnt ? w_gnt_addr : r_rom_addr;
    assign resp_valid = r_inflight[LAT-1];
    // Data is forced to zero when nobody owns it, which also covers reset.
    assign resp_data  = (|r_inflight[LAT-1]) ? rom_rd_data : {DATA_WIDTH{1'b0}};
    assign rom_rst    = ~rst_n;

endmodule : sqrt_rom_arbiter

// File: doc/sqrt_rom_arbiter.md
SQRT_ROM_ARBITER -- requirements
Module: sqrt_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the sqrt ROM (range 2..8).
REQ-002 Parameter ADDR_WIDTH, default 8: ROM address width.
REQ-003 Parameter DATA_WIDTH, default 8: ROM data width.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester lookup request.
REQ-007 req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; a request is accepted on a cycle with valid&ready.
REQ-009 resp_valid  output  NUM_REQ  one-hot marker showing which requester owns resp_data this cycle.
REQ-010 resp_data  output  DATA_WIDTH  ROM read data, shared by all requesters.
REQ-011 rom_addr  output  ADDR_WIDTH  address to the ROM instance.
REQ-012 rom_rd_data  input  DATA_WIDTH  data from the ROM instance.
REQ-013 rom_rst  output  1  active-high reset to the ROM, equal to ~rst_n.

Function
REQ-014 Arbitration SHALL be round-robin with at most one grant per cycle.
- Search starts at the requester after the last one granted.
- Out of reset, the search starts at requester 0.
REQ-015 req_ready SHALL be combinational from req_valid and the round-robin pointer.
- Exactly one bit is high when any req_valid is high; all bits are 0 otherwise.
- req_ready SHALL NOT depend on the requester's own ready.
REQ-016 rom_addr SHALL be the granted requester's address in the grant cycle.
- When there is no grant, rom_addr SHALL hold its last value and no response is tracked.
REQ-017 The grant vector SHALL be delayed through an in-flight shift register of depth LAT.
- LAT=1 by default, LAT=2 with the option in REQ-026.
- resp_valid equals the grant vector delayed by LAT cycles.
REQ-018 resp_data SHALL equal rom_rd_data aligned with resp_valid.
- resp_data is don't-care when resp_valid is 0.
REQ-019 Responses have no backpressure; each requester SHALL accept its response in the cycle resp_valid is high.
REQ-020 Full-rate throughput: continuous requests produce one response per cycle with no bubbles.
REQ-021 The round-robin pointer SHALL update only on an accepted grant.
- A requester that drops req_valid before being granted loses no fairness.
REQ-022 Simultaneous events:
- A grant and a response for the same requester in the same cycle SHALL both proceed.
- A requester may hold multiple requests in flight.

Reset
REQ-023 While rst_n=0, the following SHALL be 0:
- req_ready
- resp_valid
- the in-flight shift register
- rom_addr
- the round-robin pointer (requester 0)
- resp_data
REQ-024 On reset mid-operation, all in-flight lookups SHALL be discarded; no resp_valid pulse follows deassertion.
REQ-025 Reset deassertion SHALL take effect on the first rising clk edge after rst_n rises; the first grant is possible in that cycle.

Configuration
REQ-026 Macro SQRT_ROM_ARB_OUT_REG_EN.
- Defined: the ROM is built with its output register, and LAT=2.
- Not defined: the ROM is unregistered, and LAT=1.
- Arbitration is identical in both cases.

Structure
REQ-027 Shared package sqrt_rom_pkg SHALL hold:
- the ADDR_WIDTH and DATA_WIDTH defaults;
- the LAT constant derived from the macro;
- the NUM_REQ maximum.
REQ-028 The round-robin grant logic SHALL be the one sub-module, rr_arbiter.
- Its ports: request vector, pointer, grant vector.
- The sqrt_rom_arbiter top holds the pointer, the in-flight register and the ROM port muxing.

Verification
REQ-029 The bench SHALL use a behavioural ROM model with data = addr ^ 8'hA5 and latency LAT.
REQ-030 Single request: req0 valid, addr 8'h10 for one cycle.
- Required: req_ready=4'b0001 that cycle.
- Required: resp_valid=4'b0001 with resp_data=8'hB5 exactly LAT cycles later.
REQ-031 All four requesters continuously valid for 8 cycles, with addresses 8'h00..8'h03.
- Required grants: 0,1,2,3,0,1,2,3.
- Required: 8 responses with matching data and back-to-back resp_valid.
REQ-032 Requester 2 only, addresses 8'hFE then 8'hFF on consecutive cycles.
- Required: two consecutive responses, 8'h5B then 8'h5A, with no bubble.
REQ-033 Pointer skip: pointer after grant 1; only req0 and req3 valid.
- Required: grant 3 first, then 0.
REQ-034 Reset mid-operation: assert rst_n=0 with 1 request in flight.
- Required: resp_valid stays 0 through and after reset.
- Required: first post-reset grant with all valid goes to requester 0.
REQ-035 Idle: no req_valid for 10 cycles.
- Required: req_ready=0, resp_valid=0, rom_addr holds its last value.
